pixel_coord_tracker: RTL

PIXEL_COORD_TRACKER -- requirements
Module: pixel_coord_tracker

---
 rtl/pixel_coord_tracker.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pixel_coord_tracker.sv
// Converts a row-major linear pixel index into registered (x, y) coordinates.
// Sequential indices are tracked by increment; a jump re-locks through a serial restoring divider.
module pixel_coord_tracker #(
  parameter int H_RES = 96,
  parameter int V_RES = 64,
  parameter int IDX_W = 13,
  parameter int X_W   = 7,
  parameter int Y_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] pixel_index,
  input  logic             idx_valid,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             coord_valid,
  output logic             line_start,
  output logic             frame_start,
  output logic             locked,
  output logic             busy,
  output logic             range_err
);

  localparam int               TOTAL     = H_RES * V_RES;
  localparam logic [IDX_W:0]   TOTAL_L   = (IDX_W + 1)'(TOTAL);
  localparam logic [X_W-1:0]   X_LAST    = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(V_RES - 1);
  localparam logic [X_W:0]     DIVISOR   = (X_W + 1)'(H_RES);
  localparam int               CNT_W     = $clog2(IDX_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(IDX_W - 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    DIVIDE   = 2'd1,
    TRACK    = 2'd2
  } state_t;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < TOTAL_L;
  endfunction

  // Index following idx, wrapping at the end of the frame.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
    logic [IDX_W:0] inc;
    inc = {1'b0, idx} + (IDX_W + 1)'(1);
    return (inc >= TOTAL_L) ? '0 : inc[IDX_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             cv_q, cv_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;
  logic             re_q, re_d;
  logic [IDX_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0] quo_q, quo_d;
  logic [IDX_W-1:0] div_idx_q, div_idx_d;

  logic [X_W:0]     rem_shift;
  logic [X_W:0]     rem_sub;
  logic             q_bit;
  logic [X_W-1:0]   rem_next;
  logic [IDX_W-1:0] quo_next;
  logic [Y_W-1:0]   y_div;
  logic [X_W-1:0]   x_inc;
  logic [Y_W-1:0]   y_inc;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q, quo_q[IDX_W-1]};
    if (rem_shift >= DIVISOR) begin
      rem_sub = rem_shift - DIVISOR;
      q_bit   = 1'b1;
    end else begin
      rem_sub = rem_shift;
      q_bit   = 1'b0;
    end
    rem_next = rem_sub[X_W-1:0];
    quo_next = {quo_q[IDX_W-2:0], q_bit};
    y_div    = Y_W'(quo_next);
  end

  always_comb begin
    if (x_q == X_LAST) begin
      x_inc = '0;
      y_inc = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
    end else begin
      x_inc = x_q + X_W'(1);
      y_inc = y_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cv_d      = 1'b0;
    ls_d      = 1'b0;
    fs_d      = 1'b0;
    re_d      = 1'b0;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_idx_d = div_idx_q;
    case (state_q)
      UNLOCKED: begin
        if (idx_valid) begin
          if (!in_range(pixel_index)) begin
            re_d = 1'b1;
          end else begin
            state_d   = DIVIDE;
            rem_d     = '0;
            quo_d     = pixel_index;
            div_idx_d = pixel_index;
            cnt_d     = '0;
          end
        end
      end
      TRACK: begin
        if (idx_valid) begin
          if (!in_range(pixel_index)) begin
            re_d    = 1'b1;
            state_d = UNLOCKED;
          end else if (pixel_index == exp_q) begin
            x_d   = x_inc;
            y_d   = y_inc;
            cv_d  = 1'b1;
            ls_d  = (x_inc == '0);
            fs_d  = (x_inc == '0) && (y_inc == '0);
            exp_d = next_index(pixel_index);
          end else begin
            state_d   = DIVIDE;
            rem_d     = '0;
            quo_d     = pixel_index;
            div_idx_d = pixel_index;
            cnt_d     = '0;
          end
        end
      end
      DIVIDE: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          x_d     = rem_next;
          y_d     = y_div;
          cv_d    = 1'b1;
          ls_d    = (rem_next == '0);
          fs_d    = (rem_next == '0) && (y_div == '0);
          exp_d   = next_index(div_idx_q);
          state_d = TRACK;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNLOCKED;
      x_q     <= '0;
      y_q     <= '0;
      cv_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      re_q    <= 1'b0;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cv_q    <= cv_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      re_q    <= re_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Divider datapath is only meaningful while in DIVIDE, so it carries no reset.
  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    div_idx_q <= div_idx_d;
  end

  assign x           = x_q;
  assign y           = y_q;
  assign coord_valid = cv_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign range_err   = re_q;
  assign locked      = (state_q == TRACK);
  assign busy        = (state_q == DIVIDE);

endmodule
